// File: rtl/morph_pkg.sv
// Shared constants and types for the binary 3x3 morphological filter.
package morph_pkg;

  localparam logic MODE_ERODE  = 1'b0;
  localparam logic MODE_DILATE = 1'b1;

  localparam int DEF_WIDTH     = 640;
  localparam int DEF_HEIGHT    = 480;
  localparam int DEF_COL_WIDTH = 10;
  localparam int DEF_ROW_WIDTH = 9;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } arm_state_e;

endpackage

// File: rtl/line_buffer.sv
// One-line delay for a 1-bit stream: registered read, write every clock.
module line_buffer #(
  parameter int DEPTH  = 640,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data
);

  logic mem [DEPTH];

  // Read returns the value stored before this edge's write (previous line).
  always_ff @(posedge clk) begin
    mem[wr_addr] <= wr_data;
    rd_data      <= mem[rd_addr];
  end

endmodule

// File: rtl/window_3x3.sv
// Three 3-bit row shift registers forming the 3x3 neighbourhood; shifts only when en.
module window_3x3 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       top,
  input  logic       mid,
  input  logic       bot,
  output logic [8:0] win
);

  logic [2:0] sr_top;
  logic [2:0] sr_mid;
  logic [2:0] sr_bot;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_top <= '0;
      sr_mid <= '0;
      sr_bot <= '0;
    end else if (en) begin
      sr_top <= {sr_top[1:0], top};
      sr_mid <= {sr_mid[1:0], mid};
      sr_bot <= {sr_bot[1:0], bot};
    end
  end

  assign win = {sr_top, sr_mid, sr_bot};

endmodule

// File: rtl/morph_filter_3x3.sv
// Binary 3x3 erode/dilate on the colour mask; emits centre (r-1,c-1) for input (r,c), 3 cycles later.
module morph_filter_3x3
  import morph_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int HEIGHT    = DEF_HEIGHT,
  parameter int COL_WIDTH = DEF_COL_WIDTH,
  parameter int ROW_WIDTH = DEF_ROW_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pix_valid,
  input  logic [COL_WIDTH-1:0] col,
  input  logic [ROW_WIDTH-1:0] row,
  input  logic                 mask_in,
  input  logic                 mode,
  output logic                 mask_out,
  output logic [COL_WIDTH-1:0] col_out,
  output logic [ROW_WIDTH-1:0] row_out,
  output logic                 valid_out
);

  localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(HEIGHT - 1);
  localparam logic [ROW_WIDTH-1:0] ROW_ONE  = ROW_WIDTH'(1);
  localparam logic [COL_WIDTH-1:0] COL_ONE  = COL_WIDTH'(1);

  arm_state_e state, state_next;
  logic mode_q;
  logic frame_start;
  logic emit;

  logic                 vld_p0, emit_p0, mask_p0, mode_p0, border_p0;
  logic [COL_WIDTH-1:0] col_p0;
  logic [ROW_WIDTH-1:0] row_p0;
  logic                 mid_p0, top_p0;
  logic                 mid_wr;
  logic [COL_WIDTH-1:0] col_wr;

  logic                 vld_p1, emit_p1, mode_p1, border_p1;
  logic [COL_WIDTH-1:0] col_p1;
  logic [ROW_WIDTH-1:0] row_p1;
  logic [8:0]           win_p1;

  function automatic logic reduce_win(input logic [8:0] w, input logic m);
    logic r;
    case (m)
      MODE_ERODE:  r = &w;
      MODE_DILATE: r = |w;
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

  assign frame_start = pix_valid && (row == '0) && (col == '0);
  assign emit = pix_valid && (state == ST_ARMED) && (row != '0) && (col != '0)
                && (row <= LAST_ROW);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == ST_IDLE && frame_start) state_next = ST_ARMED;
  end

  always_ff @(posedge clk) begin
    if (reset)            mode_q <= MODE_ERODE;
    else if (frame_start) mode_q <= mode;
  end

  // Stage p0: input capture; line buffers are read with the live column
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      emit_p0 <= 1'b0;
    end else begin
      vld_p0  <= pix_valid;
      emit_p0 <= emit;
    end
  end

  always_ff @(posedge clk) begin
    if (pix_valid && !reset) begin
      mask_p0   <= mask_in;
      col_p0    <= col;
      row_p0    <= row;
      mode_p0   <= mode_q;
      border_p0 <= (row == ROW_ONE) || (col == COL_ONE);
    end
  end

  line_buffer #(.DEPTH(WIDTH), .ADDR_W(COL_WIDTH)) u_lb_mid (
    .clk     (clk),
    .wr_addr (col_p0),
    .wr_data (mask_p0),
    .rd_addr (col),
    .rd_data (mid_p0)
  );

  // Second line is fed from a held copy of the first buffer's aligned output
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      mid_wr <= mid_p0;
      col_wr <= col_p0;
    end
  end

  line_buffer #(.DEPTH(WIDTH), .ADDR_W(COL_WIDTH)) u_lb_top (
    .clk     (clk),
    .wr_addr (col_wr),
    .wr_data (mid_wr),
    .rd_addr (col),
    .rd_data (top_p0)
  );

  // Stage p1: neighbourhood window
  window_3x3 u_win (
    .clk   (clk),
    .reset (reset),
    .en    (vld_p0),
    .top   (top_p0),
    .mid   (mid_p0),
    .bot   (mask_p0),
    .win   (win_p1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      emit_p1 <= 1'b0;
    end else begin
      vld_p1  <= vld_p0;
      emit_p1 <= emit_p0;
    end
  end

  always_ff @(posedge clk) begin
    col_p1    <= col_p0;
    row_p1    <= row_p0;
    mode_p1   <= mode_p0;
    border_p1 <= border_p0;
  end

  // Output stage: reduction, border zeroing, centre coordinates
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      mask_out  <= 1'b0;
      col_out   <= '0;
      row_out   <= '0;
    end else begin
      valid_out <= vld_p1 && emit_p1;
      if (vld_p1 && emit_p1) begin
        mask_out <= border_p1 ? 1'b0 : reduce_win(win_p1, mode_p1);
        col_out  <= col_p1 - COL_ONE;
        row_out  <= row_p1 - ROW_ONE;
      end
    end
  end

endmodule
